// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: issue-op layout, writeback record
// and the sign-extension helper used by the 32-bit (W) forms.
package alu_pkg;

    localparam int RNBIT       = 2;
    localparam int RNW         = 5 + RNBIT;
    localparam int FIFO_DP_DEF = 2;
    localparam int ALU_INFO_W  = 9 + RNW + 130;

    typedef struct packed {
        logic           fun_add;
        logic           fun_sub;
        logic           fun_slt;
        logic           fun_sll;
        logic           fun_srl;
        logic           fun_sra;
        logic           fun_xor;
        logic           fun_or;
        logic           fun_and;
        logic [RNW-1:0] rd0;
        logic [63:0]    op1;
        logic [63:0]    op2;
        logic           is32;
        logic           isUsi;
    } alu_exe_info_t;

    typedef struct packed {
        logic [63:0]    res;
        logic [RNW-1:0] rd0;
    } alu_wb_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/alu_execute_chk.sv
// Simulation checker: an accepted op must carry at most one function flag.
module alu_execute_chk (
    input logic       CLK,
    input logic       RST,
    input logic       i_push,
    input logic [8:0] i_funs
);

    // Flag multiple function selects on an accepted op
    always @(posedge CLK) begin
        if (!RST && i_push) begin
            assert ($countones(i_funs) <= 1)
                else $error("alu_execute: more than one function flag on accepted op");
        end
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO between the ALU datapath and writeback; valid/full are
// registered so neither handshake output has a combinational input path.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DP = FIFO_DP_DEF
) (
    input  logic    CLK,
    input  logic    RST,
    input  logic    i_flush,
    input  logic    i_push,
    input  logic    i_pop,
    input  alu_wb_t i_wdata,
    output alu_wb_t o_rdata,
    output logic    o_valid,
    output logic    o_full
);

    localparam int PW = $clog2(DP);
    localparam int CW = PW + 1;

    alu_wb_t        r_mem [DP];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_valid;
    logic           r_full;
    logic [CW-1:0]  w_count_nxt;

    // Next occupancy; flush wins over any push/pop in the same cycle
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = {CW{1'b0}};
        end else begin
            case ({i_push, i_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointers, count and registered status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= {PW{1'b0}};
                r_rd_ptr <= {PW{1'b0}};
            end else begin
                if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != {CW{1'b0}});
            r_full  <= (w_count_nxt == CW'(DP));
        end
    end

    // Result storage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DP; i++) r_mem[i] <= '0;
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = r_valid;
    assign o_full  = r_full;

endmodule

// File: rtl/alu_execute.sv
// RV64I ALU execute stage: computes the result of the issued op and queues it
// with its rename tag for writeback.
module alu_execute
    import alu_pkg::*;
#(
    parameter int FIFO_DP = FIFO_DP_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  alu_execute_vaild,
    output logic                  alu_execute_ready,
    input  logic [ALU_INFO_W-1:0] alu_execute_info,
    input  logic                  flush,
    output logic                  alu_writeback_vaild,
    input  logic                  alu_writeback_ready,
    output logic [63:0]           alu_writeback_res,
    output logic [RNW-1:0]        alu_writeback_rd0
);

    alu_exe_info_t w_info;
    alu_wb_t       w_wdata;
    alu_wb_t       w_rdata;
    logic          w_full;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;
    logic [8:0]    w_funs;

    logic [63:0]   w_sum, w_diff;
    logic [5:0]    w_shamt;
    logic [31:0]   w_sll32, w_srl32, w_sra32;
    logic [63:0]   w_sll64, w_srl64, w_sra64;
    logic          w_lt;
    logic [63:0]   w_res;

    assign w_info = alu_exe_info_t'(alu_execute_info);
    assign w_funs = {w_info.fun_add, w_info.fun_sub, w_info.fun_slt, w_info.fun_sll, w_info.fun_srl,
                     w_info.fun_sra, w_info.fun_xor, w_info.fun_or, w_info.fun_and};

    // Result datapath; an illegal multi-flag op yields the OR of the selected results
    always_comb begin
        w_sum   = w_info.op1 + w_info.op2;
        w_diff  = w_info.op1 - w_info.op2;
        w_shamt = w_info.is32 ? {1'b0, w_info.op2[4:0]} : w_info.op2[5:0];
        w_sll32 = w_info.op1[31:0] << w_shamt[4:0];
        w_srl32 = w_info.op1[31:0] >> w_shamt[4:0];
        w_sra32 = $signed(w_info.op1[31:0]) >>> w_shamt[4:0];
        w_sll64 = w_info.op1 << w_shamt;
        w_srl64 = w_info.op1 >> w_shamt;
        w_sra64 = $signed(w_info.op1) >>> w_shamt;
        w_lt    = w_info.isUsi ? (w_info.op1 < w_info.op2)
                               : ($signed(w_info.op1) < $signed(w_info.op2));
        w_res   = ({64{w_info.fun_add}} & (w_info.is32 ? sext32(w_sum[31:0])  : w_sum))
                | ({64{w_info.fun_sub}} & (w_info.is32 ? sext32(w_diff[31:0]) : w_diff))
                | ({64{w_info.fun_slt}} & {63'd0, w_lt})
                | ({64{w_info.fun_sll}} & (w_info.is32 ? sext32(w_sll32) : w_sll64))
                | ({64{w_info.fun_srl}} & (w_info.is32 ? sext32(w_srl32) : w_srl64))
                | ({64{w_info.fun_sra}} & (w_info.is32 ? sext32(w_sra32) : w_sra64))
                | ({64{w_info.fun_xor}} & (w_info.op1 ^ w_info.op2))
                | ({64{w_info.fun_or}}  & (w_info.op1 | w_info.op2))
                | ({64{w_info.fun_and}} & (w_info.op1 & w_info.op2));
    end

    assign w_push        = alu_execute_vaild & ~w_full & ~flush;
    assign w_pop         = w_valid & alu_writeback_ready;
    assign w_wdata.res   = w_res;
    assign w_wdata.rd0   = w_info.rd0;

    alu_result_fifo #(.DP(FIFO_DP)) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_flush (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_valid (w_valid),
        .o_full  (w_full)
    );

    alu_execute_chk u_chk (
        .CLK    (CLK),
        .RST    (RST),
        .i_push (w_push),
        .i_funs (w_funs)
    );

    assign alu_execute_ready   = ~w_full;
    assign alu_writeback_vaild = w_valid;
    assign alu_writeback_res   = w_rdata.res;
    assign alu_writeback_rd0   = w_rdata.rd0;

endmodule

// File: tb/tb_alu_execute.sv
// Directed bench for alu_execute: vector table for the arithmetic plus
// hand-written stall, flush and asynchronous-reset sequences.
module tb_alu_execute;
    import alu_pkg::*;

    localparam logic [8:0] F_ADD = 9'b100000000;
    localparam logic [8:0] F_SUB = 9'b010000000;
    localparam logic [8:0] F_SLT = 9'b001000000;
    localparam logic [8:0] F_SLL = 9'b000100000;
    localparam logic [8:0] F_SRL = 9'b000010000;
    localparam logic [8:0] F_SRA = 9'b000001000;
    localparam logic [8:0] F_XOR = 9'b000000100;
    localparam logic [8:0] F_OR  = 9'b000000010;
    localparam logic [8:0] F_AND = 9'b000000001;
    localparam logic [8:0] F_NON = 9'b000000000;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  alu_execute_vaild;
    logic                  alu_execute_ready;
    logic [ALU_INFO_W-1:0] alu_execute_info;
    logic                  flush;
    logic                  alu_writeback_vaild;
    logic                  alu_writeback_ready;
    logic [63:0]           alu_writeback_res;
    logic [RNW-1:0]        alu_writeback_rd0;

    always #5 CLK = ~CLK;

    alu_execute #(.FIFO_DP(2)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .alu_execute_vaild   (alu_execute_vaild),
        .alu_execute_ready   (alu_execute_ready),
        .alu_execute_info    (alu_execute_info),
        .flush               (flush),
        .alu_writeback_vaild (alu_writeback_vaild),
        .alu_writeback_ready (alu_writeback_ready),
        .alu_writeback_res   (alu_writeback_res),
        .alu_writeback_rd0   (alu_writeback_rd0)
    );

    typedef struct {
        string       name;
        logic [8:0]  funs;
        logic [63:0] op1;
        logic [63:0] op2;
        logic        is32;
        logic        isUsi;
        logic [63:0] exp;
    } vec_t;

    typedef struct packed {
        logic [63:0]    res;
        logic [RNW-1:0] rd0;
    } exp_t;

    vec_t vt[$];
    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] f, input logic [RNW-1:0] rd,
                         input logic [63:0] a, input logic [63:0] b, input logic w, input logic u);
        alu_execute_vaild = v;
        alu_execute_info  = {f, rd, a, b, w, u};
    endtask

    task automatic addv(input string nm, input logic [8:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic u, input logic [63:0] e);
        vec_t v;
        v.name = nm; v.funs = f; v.op1 = a; v.op2 = b; v.is32 = w; v.isUsi = u; v.exp = e;
        vt.push_back(v);
    endtask

    initial begin
        int   k;
        int   pops;
        exp_t e;

        addv("addw_ovf",  F_ADD, 64'h0000_0000_7FFF_FFFF, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000);
        addv("add64",     F_ADD, 64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_8000_0000);
        addv("sub64",     F_SUB, 64'd3, 64'd5, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        addv("subw",      F_SUB, 64'h0000_0001_0000_0000, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        addv("sra63",     F_SRA, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        addv("sraw",      F_SRA, 64'h0000_0000_8000_0000, 64'h21, 1'b1, 1'b0, 64'hFFFF_FFFF_C000_0000);
        addv("slt",       F_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd1);
        addv("sltu",      F_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'd0);
        addv("slt_w_ign", F_SLT, 64'h0000_0001_0000_0000, 64'd1, 1'b1, 1'b0, 64'd0);
        addv("srlw",      F_SRL, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4, 1'b1, 1'b0, 64'h0000_0000_0FFF_FFFF);
        addv("sll63",     F_SLL, 64'd1, 64'd63, 1'b0, 1'b0, 64'h8000_0000_0000_0000);
        addv("sllw",      F_SLL, 64'd1, 64'h3F, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000);
        addv("srl_sh0",   F_SRL, 64'h8000_0000_0000_0000, 64'h40, 1'b0, 1'b0, 64'h8000_0000_0000_0000);
        addv("xor",       F_XOR, 64'hFF00, 64'h0FF0, 1'b0, 1'b0, 64'hF0F0);
        addv("or",        F_OR,  64'hF000, 64'h000F, 1'b0, 1'b0, 64'hF00F);
        addv("and_w_ign", F_AND, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b1, 1'b0,
             64'h8000_0000_0000_0001);
        addv("noflag",    F_NON, 64'd5, 64'd7, 1'b0, 1'b0, 64'd0);

        // Reset held for 3 cycles
        RST = 1'b1;
        flush = 1'b0;
        alu_writeback_ready = 1'b0;
        drive(1'b0, F_NON, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_vaild_in", 64'(alu_writeback_vaild), 64'd0);
        chk("rst_ready_in", 64'(alu_execute_ready), 64'd1);
        RST = 1'b0;
        step();
        chk("rst_vaild", 64'(alu_writeback_vaild), 64'd0);
        chk("rst_ready", 64'(alu_execute_ready), 64'd1);
        chk("rst_res", alu_writeback_res, 64'd0);
        chk("rst_rd0", 64'(alu_writeback_rd0), 64'd0);

        // Table: one op per cycle, writeback always ready
        alu_writeback_ready = 1'b1;
        foreach (vt[i]) begin
            drive(1'b1, vt[i].funs, 7'(i + 1), vt[i].op1, vt[i].op2, vt[i].is32, vt[i].isUsi);
            step();
            chk({vt[i].name, "_vaild"}, 64'(alu_writeback_vaild), 64'd1);
            chk(vt[i].name, alu_writeback_res, vt[i].exp);
            chk({vt[i].name, "_rd0"}, 64'(alu_writeback_rd0), 64'(i + 1));
        end
        drive(1'b0, F_NON, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        chk("drained_vaild", 64'(alu_writeback_vaild), 64'd0);

        // Stall writeback 4 cycles under continuous issue, then drain 10 ops
        k = 0;
        pops = 0;
        alu_writeback_ready = 1'b0;
        for (int c = 0; c < 40 && (k < 10 || q.size() != 0); c++) begin
            if (c == 4) alu_writeback_ready = 1'b1;
            if (k < 10) drive(1'b1, F_ADD, 7'(k + 3), 64'd1000 + 64'(k), 64'd0, 1'b0, 1'b0);
            else        drive(1'b0, F_NON, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0);
            chk("st_ready", 64'(alu_execute_ready), 64'(q.size() < 2));
            chk("st_vaild", 64'(alu_writeback_vaild), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("st_head_res", alu_writeback_res, q[0].res);
                chk("st_head_rd0", 64'(alu_writeback_rd0), 64'(q[0].rd0));
                if (alu_writeback_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
            if (alu_execute_vaild && alu_execute_ready) begin
                e.res = 64'd1000 + 64'(k);
                e.rd0 = 7'(k + 3);
                q.push_back(e);
                k++;
            end
            if (c == 3) chk("st_pushes", 64'(k), 64'd2);
            step();
        end
        chk("st_pops", 64'(pops), 64'd10);
        q.delete();

        // Flush with 2 queued; offered op and in-flight pop
        alu_writeback_ready = 1'b0;
        drive(1'b1, F_ADD, 7'd1, 64'd11, 64'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, F_ADD, 7'd2, 64'd22, 64'd0, 1'b0, 1'b0);
        step();
        chk("fl_full_ready", 64'(alu_execute_ready), 64'd0);
        chk("fl_head", alu_writeback_res, 64'd11);
        flush = 1'b1;
        alu_writeback_ready = 1'b1;
        drive(1'b1, F_ADD, 7'd3, 64'd33, 64'd0, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, F_NON, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("fl_vaild", 64'(alu_writeback_vaild), 64'd0);
        chk("fl_ready", 64'(alu_execute_ready), 64'd1);
        step();
        chk("fl_vaild2", 64'(alu_writeback_vaild), 64'd0);

        // Flush with 1 queued and an op the stage would otherwise accept
        alu_writeback_ready = 1'b0;
        drive(1'b1, F_ADD, 7'd4, 64'd44, 64'd0, 1'b0, 1'b0);
        step();
        flush = 1'b1;
        alu_writeback_ready = 1'b1;
        drive(1'b1, F_ADD, 7'd5, 64'd55, 64'd0, 1'b0, 1'b0);
        chk("fl2_ready", 64'(alu_execute_ready), 64'd1);
        chk("fl2_head", alu_writeback_res, 64'd44);
        step();
        flush = 1'b0;
        drive(1'b0, F_NON, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("fl2_vaild", 64'(alu_writeback_vaild), 64'd0);
        step();
        chk("fl2_vaild2", 64'(alu_writeback_vaild), 64'd0);
        drive(1'b1, F_XOR, 7'd6, 64'h66, 64'h0, 1'b0, 1'b0);
        step();
        drive(1'b0, F_NON, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("post_fl_res", alu_writeback_res, 64'h66);
        chk("post_fl_rd0", 64'(alu_writeback_rd0), 64'd6);
        step();

        // Asynchronous reset mid-stream
        alu_writeback_ready = 1'b0;
        drive(1'b1, F_ADD, 7'd7, 64'd77, 64'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, F_NON, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("ar_pre_vaild", 64'(alu_writeback_vaild), 64'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_vaild", 64'(alu_writeback_vaild), 64'd0);
        chk("ar_ready", 64'(alu_execute_ready), 64'd1);
        chk("ar_res", alu_writeback_res, 64'd0);
        step();
        RST = 1'b0;
        step();
        chk("ar_post_vaild", 64'(alu_writeback_vaild), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
